instruction_cache: RTL

Direct-mapped instruction cache between the IF stage (PC) and the 128-bit block instruction memory.
- Serves 32-bit instructions on a hit in the same cycle.
- On a miss, stalls the CPU, fetches one 16-byte block over the memory READ/BUSYWAIT handshake, fills the line, then replays the lookup.

---
 rtl/instruction_cache_pkg.sv | 22 ++
 rtl/icache_store.sv | 46 ++++
 rtl/instruction_cache.sv | 112 +++++++++++
 3 files changed

// File: rtl/instruction_cache_pkg.sv
// Shared geometry, FSM encoding and word-select helper for the instruction cache.
// Constants only; no logic, no latency, no flow control.
// Default geometry: 8 lines x 16 B, 32-bit byte addresses, 128-bit lines.
package instruction_cache_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int INDEX_BITS  = 3;
    localparam int OFFSET_BITS = 4;
    localparam int TAG_BITS    = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;
    localparam int BLOCK_BITS  = 128;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;

    // Word n of a line occupies bits [32n+31:32n].
    function automatic logic [31:0] word_sel(input logic [BLOCK_BITS-1:0] line,
                                             input logic [1:0]            sel);
        return line[sel*32 +: 32];
    endfunction

endpackage

// File: rtl/icache_store.sv
// Line storage: data, tag and valid arrays for the direct-mapped cache.
// Read port is combinational; the write port commits on the clock edge.
// No backpressure; only valid is cleared by reset, data and tags keep stale contents.
module icache_store #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 25,
    parameter int BLOCK_BITS = 128
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [BLOCK_BITS-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [BLOCK_BITS-1:0] wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [BLOCK_BITS-1:0] data_q [LINES];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache between the fetch stage and block memory.
// Hits return the word combinationally; a miss costs 1 + memory latency + 1 cycles.
// BUSYWAIT stalls the CPU while a fetch is pending; memory paces the fill via MEM_BUSYWAIT.
module instruction_cache #(
    parameter int INDEX_BITS = instruction_cache_pkg::INDEX_BITS,
    parameter int ADDR_WIDTH = instruction_cache_pkg::ADDR_WIDTH,
    parameter int BLOCK_BITS = instruction_cache_pkg::BLOCK_BITS
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    output logic [31:0]           READDATA,
    output logic                  BUSYWAIT,
    output logic                  MEM_READ,
    output logic [ADDR_WIDTH-5:0] MEM_ADDRESS,
    input  logic [BLOCK_BITS-1:0] MEM_READDATA,
    input  logic                  MEM_BUSYWAIT
);

    import instruction_cache_pkg::OFFSET_BITS;
    import instruction_cache_pkg::ST_IDLE;
    import instruction_cache_pkg::ST_FETCH;
    import instruction_cache_pkg::ST_UPDATE;
    import instruction_cache_pkg::word_sel;

    localparam int TAG_BITS      = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;
    localparam int BLK_ADDR_BITS = ADDR_WIDTH - OFFSET_BITS;

    logic [1:0]               state_q;
    logic                     first_q;
    logic [BLK_ADDR_BITS-1:0] miss_addr_q;
    logic [BLOCK_BITS-1:0]    fill_q;
    logic [31:0]              rdata_q;

    logic [INDEX_BITS-1:0]    cur_index;
    logic [TAG_BITS-1:0]      cur_tag;
    logic                     line_valid;
    logic [TAG_BITS-1:0]      line_tag;
    logic [BLOCK_BITS-1:0]    line_data;
    logic                     hit;
    logic                     lookup_hit;
    logic [31:0]              hit_word;
    logic                     unused_byte_offset;

    assign cur_index          = ADDRESS[OFFSET_BITS +: INDEX_BITS];
    assign cur_tag            = ADDRESS[ADDR_WIDTH-1 -: TAG_BITS];
    assign unused_byte_offset = ^ADDRESS[1:0];

    icache_store #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS),
        .BLOCK_BITS (BLOCK_BITS)
    ) u_store (
        .CLK      (CLK),
        .RESET    (RESET),
        .rd_index (cur_index),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (state_q == ST_UPDATE),
        .wr_index (miss_addr_q[INDEX_BITS-1:0]),
        .wr_tag   (miss_addr_q[BLK_ADDR_BITS-1 -: TAG_BITS]),
        .wr_data  (fill_q)
    );

    // Lookups are only honoured in IDLE so a stale line cannot answer mid-fill.
    assign hit        = READ & line_valid & (line_tag == cur_tag);
    assign lookup_hit = hit & (state_q == ST_IDLE);
    assign hit_word   = word_sel(line_data, ADDRESS[3:2]);

    assign READDATA    = lookup_hit ? hit_word : rdata_q;
    assign BUSYWAIT    = READ & ~lookup_hit;
    assign MEM_READ    = (state_q == ST_FETCH);
    assign MEM_ADDRESS = miss_addr_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            first_q     <= 1'b0;
            miss_addr_q <= '0;
            rdata_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lookup_hit) begin
                        rdata_q <= hit_word;
                    end else if (READ) begin
                        miss_addr_q <= ADDRESS[ADDR_WIDTH-1:OFFSET_BITS];
                        first_q     <= 1'b1;
                        state_q     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // The entry edge may still see MEM_BUSYWAIT low before memory reacts.
                    first_q <= 1'b0;
                    if (!first_q && !MEM_BUSYWAIT) begin
                        state_q <= ST_UPDATE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (state_q == ST_FETCH && !first_q && !MEM_BUSYWAIT) begin
            fill_q <= MEM_READDATA;
        end
    end

endmodule
